// File: rtl/mem_arbiter_if.sv
// Signal bundle around mem_arbiter: cache requests, the shared memory port and fill returns.
// master = arbiter side, slave = cache controllers plus memory model.
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int IDX_W  = 3
);
    logic              icache_miss;
    logic [ADDR_W-1:0] icache_miss_addr;
    logic              dcache_miss;
    logic [ADDR_W-1:0] dcache_miss_addr;
    logic              dcache_wr_req;
    logic [ADDR_W-1:0] dcache_wr_addr;
    logic [DATA_W-1:0] dcache_wr_data;
    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_out;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_data_valid;
    logic [DATA_W-1:0] fill_data;
    logic [IDX_W-1:0]  fill_word_idx;
    logic              fill_icache_we;
    logic              fill_dcache_we;
    logic              fill_done_i;
    logic              fill_done_d;
    logic              wr_ack;
    logic              busy;

    modport master (
        input  icache_miss, icache_miss_addr, dcache_miss, dcache_miss_addr,
        input  dcache_wr_req, dcache_wr_addr, dcache_wr_data,
        input  mem_data_in, mem_data_valid,
        output mem_en, mem_wr, mem_addr, mem_data_out,
        output fill_data, fill_word_idx, fill_icache_we, fill_dcache_we,
        output fill_done_i, fill_done_d, wr_ack, busy
    );

    modport slave (
        output icache_miss, icache_miss_addr, dcache_miss, dcache_miss_addr,
        output dcache_wr_req, dcache_wr_addr, dcache_wr_data,
        output mem_data_in, mem_data_valid,
        input  mem_en, mem_wr, mem_addr, mem_data_out,
        input  fill_data, fill_word_idx, fill_icache_we, fill_dcache_we,
        input  fill_done_i, fill_done_d, wr_ack, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one pipelined main-memory port between I-cache fills, D-cache fills and D-cache stores.
// A fill issues one read per cycle for the whole block and routes returned words to the missing cache.
module mem_arbiter #(
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16,
    parameter int WORDS_PER_BLOCK = 8,
    parameter int MEM_LATENCY     = 4
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus
);
    localparam int IDX_W = $clog2(WORDS_PER_BLOCK);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(2 * WORDS_PER_BLOCK - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(WORDS_PER_BLOCK - 1);
    // With a latency of a full block or more no word can come back while reads are still issuing.
    localparam bit RET_DURING_ISSUE = (MEM_LATENCY < WORDS_PER_BLOCK);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_WRITE      = 3'd1;
    localparam logic [2:0] S_FILL_ISSUE = 3'd2;
    localparam logic [2:0] S_FILL_WAIT  = 3'd3;
    localparam logic [2:0] S_DONE       = 3'd4;

    logic [2:0]        r_state;
    logic [2:0]        w_state_next;
    logic [IDX_W-1:0]  r_issue_cnt;
    logic [IDX_W-1:0]  r_ret_cnt;
    logic              r_owner_i;
    logic [ADDR_W-1:0] r_base;

    logic              w_ret_we;
    logic              w_last_issue;
    logic              w_last_ret;
    logic              w_fill_req;
    logic [ADDR_W-1:0] w_miss_addr;

    assign w_ret_we     = bus.mem_data_valid &&
                          ((r_state == S_FILL_WAIT) || (RET_DURING_ISSUE && r_state == S_FILL_ISSUE));
    assign w_last_issue = (r_issue_cnt == LAST_IDX);
    assign w_last_ret   = w_ret_we && (r_ret_cnt == LAST_IDX);
    assign w_fill_req   = bus.dcache_miss || bus.icache_miss;
    assign w_miss_addr  = bus.dcache_miss ? bus.dcache_miss_addr : bus.icache_miss_addr;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.dcache_wr_req)
                    w_state_next = S_WRITE;
                else if (w_fill_req)
                    w_state_next = S_FILL_ISSUE;
            end
            S_WRITE:      w_state_next = S_IDLE;
            S_FILL_ISSUE: begin
                if (w_last_issue)
                    w_state_next = w_last_ret ? S_DONE : S_FILL_WAIT;
            end
            S_FILL_WAIT: begin
                if (w_last_ret)
                    w_state_next = S_DONE;
            end
            S_DONE:       w_state_next = S_IDLE;
            default:      w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_issue_cnt <= '0;
            r_ret_cnt   <= '0;
            r_owner_i   <= 1'b0;
            r_base      <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_IDLE && !bus.dcache_wr_req && w_fill_req) begin
                // D side wins; a pending I miss simply waits for the next IDLE.
                r_owner_i   <= !bus.dcache_miss;
                r_base      <= w_miss_addr & ALIGN_MASK;
                r_issue_cnt <= '0;
                r_ret_cnt   <= '0;
            end else begin
                if (r_state == S_FILL_ISSUE)
                    r_issue_cnt <= r_issue_cnt + IDX_W'(1);
                if (w_ret_we)
                    r_ret_cnt <= r_ret_cnt + IDX_W'(1);
            end
        end
    end

    always_comb begin
        bus.mem_en         = 1'b0;
        bus.mem_wr         = 1'b0;
        bus.mem_addr       = '0;
        bus.mem_data_out   = '0;
        bus.fill_data      = '0;
        bus.fill_word_idx  = '0;
        bus.fill_icache_we = 1'b0;
        bus.fill_dcache_we = 1'b0;
        bus.fill_done_i    = 1'b0;
        bus.fill_done_d    = 1'b0;
        bus.wr_ack         = 1'b0;
        bus.busy           = (r_state != S_IDLE);
        case (r_state)
            S_WRITE: begin
                bus.mem_en       = 1'b1;
                bus.mem_wr       = 1'b1;
                bus.mem_addr     = bus.dcache_wr_addr;
                bus.mem_data_out = bus.dcache_wr_data;
                bus.wr_ack       = 1'b1;
            end
            S_FILL_ISSUE: begin
                bus.mem_en   = 1'b1;
                bus.mem_addr = r_base + ADDR_W'({r_issue_cnt, 1'b0});
            end
            S_DONE: begin
                bus.fill_done_i = r_owner_i;
                bus.fill_done_d = !r_owner_i;
            end
            default: ;
        endcase
        if (w_ret_we) begin
            bus.fill_data      = bus.mem_data_in;
            bus.fill_word_idx  = r_ret_cnt;
            bus.fill_icache_we = r_owner_i;
            bus.fill_dcache_we = !r_owner_i;
        end
    end
endmodule
